// File: rtl/i2c_slave_if.sv
// Logic-level signals between the I2C master side and the slave endpoint.
// The open-drain sda line is a top-level inout wire on the slave, not part of this bundle.
interface i2c_slave_if;
    logic       scl;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;

    modport slave (
        input  scl,
        input  tx_data,
        output rx_data,
        output rx_valid,
        output addr_match,
        output busy
    );

    modport master (
        output scl,
        output tx_data,
        input  rx_data,
        input  rx_valid,
        input  addr_match,
        input  busy
    );
endinterface

// File: rtl/i2c_slave.sv
// I2C slave endpoint: oversampled scl/sda, START/STOP detection, 7-bit address match,
// ACK generation, byte receive on write and byte return on read. Never stretches scl.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b0010101
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire         sda,
    i2c_slave_if.slave  bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                byte_full;
    logic                rw;
    logic                ack_seen;
    logic                sda_low;
    logic                sda_in;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Open-drain drive; sda_low is a register so reset releases the line immediately.
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

    // Two-flop synchronizers plus one history flop for edge detection; idle bus is high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
        end else begin
            scl_s1 <= bus.scl; scl_s2 <= scl_s1; scl_h <= scl_s2;
            sda_s1 <= sda_in;  sda_s2 <= sda_s1; sda_h <= sda_s2;
        end
    end

    logic scl_rise_c, scl_fall_c, start_c, stop_c;
    assign scl_rise_c = scl_s2 & ~scl_h;
    assign scl_fall_c = ~scl_s2 & scl_h;
    assign start_c    = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_c     = scl_s2 & scl_h & ~sda_h & sda_s2;

    // Protocol FSM; START/STOP take priority over any scl edge seen in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            byte_full      <= 1'b0;
            rw             <= 1'b0;
            ack_seen       <= 1'b0;
            sda_low        <= 1'b0;
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.addr_match <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (start_c) begin
                bus.busy       <= 1'b1;
                bus.addr_match <= 1'b0;
                bit_cnt        <= '0;
                byte_full      <= 1'b0;
                ack_seen       <= 1'b0;
                sda_low        <= 1'b0;
                state          <= ADDR;
            end else if (stop_c) begin
                bus.busy       <= 1'b0;
                bus.addr_match <= 1'b0;
                bit_cnt        <= '0;
                byte_full      <= 1'b0;
                ack_seen       <= 1'b0;
                sda_low        <= 1'b0;
                state          <= IDLE;
            end else begin
                unique case (state)
                    ADDR: begin
                        if (scl_rise_c) begin
                            shreg     <= {shreg[BYTE_W-2:0], sda_s2};
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            byte_full <= (bit_cnt == CNT_W'(7));
                        end else if (scl_fall_c && byte_full) begin
                            byte_full <= 1'b0;
                            if (shreg[BYTE_W-1:1] == SLAVE_ADDR) begin
                                sda_low        <= 1'b1;
                                bus.addr_match <= 1'b1;
                                rw             <= shreg[0];
                                state          <= ADDR_ACK;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall_c) begin
                            bit_cnt <= '0;
                            if (!rw) begin
                                sda_low <= 1'b0;
                                state   <= WRITE;
                            end else begin
                                shreg   <= bus.tx_data;
                                sda_low <= ~bus.tx_data[BYTE_W-1];
                                state   <= READ;
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise_c) begin
                            shreg   <= {shreg[BYTE_W-2:0], sda_s2};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(7)) begin
                                bus.rx_data  <= {shreg[BYTE_W-2:0], sda_s2};
                                bus.rx_valid <= 1'b1;
                                byte_full    <= 1'b1;
                            end
                        end else if (scl_fall_c && byte_full) begin
                            byte_full <= 1'b0;
                            sda_low   <= 1'b1;
                            state     <= WRITE_ACK;
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall_c) begin
                            sda_low <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WRITE;
                        end
                    end
                    READ: begin
                        if (scl_rise_c) begin
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            byte_full <= (bit_cnt == CNT_W'(7));
                        end else if (scl_fall_c) begin
                            if (byte_full) begin
                                byte_full <= 1'b0;
                                sda_low   <= 1'b0;
                                state     <= READ_ACK;
                            end else begin
                                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                                sda_low <= ~shreg[BYTE_W-2];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise_c) begin
                            if (!sda_s2) begin
                                ack_seen <= 1'b1;
                            end else begin
                                sda_low        <= 1'b0;
                                bus.addr_match <= 1'b0;
                                state          <= WAIT_STOP;
                            end
                        end else if (scl_fall_c && ack_seen) begin
                            ack_seen <= 1'b0;
                            shreg    <= bus.tx_data;
                            sda_low  <= ~bus.tx_data[BYTE_W-1];
                            bit_cnt  <= '0;
                            state    <= READ;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                        sda_low <= 1'b0;
                    end
                    default: begin
                        sda_low <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
